// File: rtl/registro_universal_if.sv
// ============================================================================
// Module   : registro_universal_if
// Purpose  : Command/data/status bundle for the universal register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface registro_universal_if #(
  parameter int WIDTH = 12
);
  localparam int CW = $clog2(WIDTH);

  logic             EN;
  logic [2:0]       MODE;
  logic [CW-1:0]    CNT;
  logic [WIDTH-1:0] L;
  logic             SIN_R;
  logic             SIN_L;
  logic [WIDTH-1:0] QR;
  logic             SOUT_L;
  logic             SOUT_R;
  logic             BUSY;
  logic             ZERO;
  logic             OVF;
  logic             PAR;

  modport master (
    output EN, MODE, CNT, L, SIN_R, SIN_L,
    input  QR, SOUT_L, SOUT_R, BUSY, ZERO, OVF, PAR
  );

  modport slave (
    input  EN, MODE, CNT, L, SIN_R, SIN_L,
    output QR, SOUT_L, SOUT_R, BUSY, ZERO, OVF, PAR
  );
endinterface

`default_nettype wire

// File: rtl/registro_universal.sv
// ============================================================================
// Module   : registro_universal
// Purpose  : WIDTH-bit universal register (load/shift/rotate/count) with burst
//            shifter FSM and status flags. Optional: REGISTRO_PARIDAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module registro_universal #(
  parameter int WIDTH = 12
) (
  input  wire                  CLK,
  input  wire                  CLR,
  registro_universal_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    c_REM_ONE = CW'(1);
  localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_right;
  logic             r_rotate;
  logic [CW-1:0]    r_rem;
  logic [WIDTH-1:0] r_qr;
  logic             r_ovf;

  // One shift/rotate step; rotates recirculate the bit leaving the far end.
  function automatic logic [WIDTH-1:0] f_step(
    input logic [WIDTH-1:0] q,
    input logic             right,
    input logic             rot,
    input logic             sr,
    input logic             sl
  );
    logic w_in;
    if (right) begin
      w_in = rot ? q[0] : sl;
      return {w_in, q[WIDTH-1:1]};
    end else begin
      w_in = rot ? q[WIDTH-1] : sr;
      return {q[WIDTH-2:0], w_in};
    end
  endfunction

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state  <= S_IDLE;
      r_right  <= 1'b0;
      r_rotate <= 1'b0;
      r_rem    <= '0;
      r_qr     <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.EN) begin
            case (bus.MODE)
              3'b001: begin
                r_qr  <= bus.L;
                r_ovf <= 1'b0;
              end
              3'b110: begin
                r_qr <= r_qr + c_ONE;
                if (&r_qr) r_ovf <= 1'b1;
              end
              3'b111: begin
                r_qr <= r_qr - c_ONE;
                if (r_qr == '0) r_ovf <= 1'b1;
              end
              3'b010, 3'b011, 3'b100, 3'b101: begin
                // First step of the burst happens on the accepting edge.
                r_right  <= bus.MODE[0];
                r_rotate <= bus.MODE[2];
                r_qr     <= f_step(r_qr, bus.MODE[0], bus.MODE[2],
                                   bus.SIN_R, bus.SIN_L);
                if (bus.CNT != '0) begin
                  r_state <= S_BURST;
                  r_rem   <= bus.CNT;
                end
              end
              default: ;
            endcase
          end
        end
        S_BURST: begin
          r_qr  <= f_step(r_qr, r_right, r_rotate, bus.SIN_R, bus.SIN_L);
          r_rem <= r_rem - c_REM_ONE;
          if (r_rem == c_REM_ONE) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.QR     = r_qr;
  assign bus.OVF    = r_ovf;
  assign bus.BUSY   = (r_state == S_BURST);
  assign bus.ZERO   = (r_qr == '0);
  assign bus.SOUT_L = r_qr[WIDTH-1];
  assign bus.SOUT_R = r_qr[0];

`ifdef REGISTRO_PARIDAD_EN
  assign bus.PAR = ^r_qr;
`else
  assign bus.PAR = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_registro_universal.sv
// ============================================================================
// Module   : tb_registro_universal
// Purpose  : Directed + randomized self-checking bench for registro_universal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_registro_universal;
  localparam int W    = 12;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic clr;

  registro_universal_if #(.WIDTH(W)) bus ();

  registro_universal #(.WIDTH(W)) u_dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integers, pending-step count instead of FSM.
  int m_q;
  int m_ovf;
  int m_left;
  int m_op;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_step(input int q, input int op, input int sr, input int sl);
    case (op)
      2:       return ((q << 1) | sr) & MASK;
      3:       return (q >> 1) | (sl << (W - 1));
      4:       return ((q << 1) | (q >> (W - 1))) & MASK;
      default: return (q >> 1) | ((q & 1) << (W - 1));
    endcase
  endfunction

  task automatic model_reset();
    m_q = 0; m_ovf = 0; m_left = 0; m_op = 0;
  endtask

  task automatic model_step();
    int mode;
    if (!clr) begin
      model_reset();
      return;
    end
    mode = int'(bus.MODE);
    if (m_left > 0) begin
      m_q = f_step(m_q, m_op, int'(bus.SIN_R), int'(bus.SIN_L));
      m_left--;
    end else if (bus.EN) begin
      case (mode)
        1: begin m_q = int'(bus.L); m_ovf = 0; end
        6: begin if (m_q == MASK) m_ovf = 1; m_q = (m_q + 1) & MASK; end
        7: begin if (m_q == 0) m_ovf = 1; m_q = (m_q - 1) & MASK; end
        2, 3, 4, 5: begin
          m_op   = mode;
          m_q    = f_step(m_q, m_op, int'(bus.SIN_R), int'(bus.SIN_L));
          m_left = int'(bus.CNT);
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    int exp_par;
`ifdef REGISTRO_PARIDAD_EN
    exp_par = $countones(m_q) % 2;
`else
    exp_par = 0;
`endif
    chk("QR",     int'(bus.QR),     m_q);
    chk("BUSY",   int'(bus.BUSY),   (m_left > 0) ? 1 : 0);
    chk("OVF",    int'(bus.OVF),    m_ovf);
    chk("ZERO",   int'(bus.ZERO),   (m_q == 0) ? 1 : 0);
    chk("SOUT_L", int'(bus.SOUT_L), (m_q >> (W - 1)) & 1);
    chk("SOUT_R", int'(bus.SOUT_R), m_q & 1);
    chk("PAR",    int'(bus.PAR),    exp_par);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cmd(input int en, input int mode, input int cnt, input int l,
                     input int sr, input int sl);
    bus.EN    = en[0];
    bus.MODE  = mode[2:0];
    bus.CNT   = cnt[3:0];
    bus.L     = l[W-1:0];
    bus.SIN_R = sr[0];
    bus.SIN_L = sl[0];
    cycle();
  endtask

  task automatic async_reset();
    clr = 1'b0;
    #1;
    model_reset();
    compare();
    cycle();
    clr = 1'b1;
  endtask

  initial begin
    int exp_par7;
    bus.EN = 1'b0; bus.MODE = 3'd0; bus.CNT = '0; bus.L = '0;
    bus.SIN_R = 1'b0; bus.SIN_L = 1'b0;
    clr = 1'b1;
    model_reset();
    #3 clr = 1'b0;
    @(negedge clk);
    compare();
    chk("rst_QR",   int'(bus.QR),   0);
    chk("rst_ZERO", int'(bus.ZERO), 1);
    chk("rst_BUSY", int'(bus.BUSY), 0);
    clr = 1'b1;

    // Reset and load
    cmd(1, 1, 0, 'hA5C, 0, 0);
    chk("load_A5C", int'(bus.QR), 'hA5C);

    // Burst shift left with a command during BUSY
    cmd(1, 1, 0, 'h001, 0, 0);
    cmd(1, 2, 3, 0, 1, 0);
    chk("burst_s0", int'(bus.QR), 'h003);
    chk("burst_b0", int'(bus.BUSY), 1);
    cmd(1, 1, 0, 'h000, 1, 0);
    chk("burst_s1", int'(bus.QR), 'h007);
    cmd(0, 0, 0, 0, 1, 0);
    chk("burst_s2", int'(bus.QR), 'h00F);
    chk("burst_b2", int'(bus.BUSY), 1);
    cmd(0, 0, 0, 0, 1, 0);
    chk("burst_s3", int'(bus.QR), 'h01F);
    chk("burst_b3", int'(bus.BUSY), 0);

    // Rotate wrap
    cmd(1, 1, 0, 'h801, 0, 0);
    cmd(1, 5, 0, 0, 0, 0);
    chk("rotr_C00", int'(bus.QR), 'hC00);
    chk("rotr_busy", int'(bus.BUSY), 0);
    cmd(1, 4, 11, 0, 0, 0);
    for (int i = 0; i < 11; i++) cmd(0, 0, 0, 0, 0, 0);
    chk("rotl_12", int'(bus.QR), 'hC00);
    chk("rotl_busy", int'(bus.BUSY), 0);

    // Count wrap
    cmd(1, 1, 0, 'hFFF, 0, 0);
    cmd(1, 6, 0, 0, 0, 0);
    chk("up_wrap", int'(bus.QR), 0);
    chk("up_ovf", int'(bus.OVF), 1);
    chk("up_zero", int'(bus.ZERO), 1);
    cmd(1, 7, 0, 0, 0, 0);
    chk("dn_wrap", int'(bus.QR), 'hFFF);
    chk("dn_ovf", int'(bus.OVF), 1);
    cmd(1, 1, 0, 'h123, 0, 0);
    chk("ld_ovfclr", int'(bus.OVF), 0);

    // Reset mid-burst
    cmd(1, 3, 7, 0, 1, 0);
    cmd(0, 0, 0, 0, 1, 0);
    chk("mid_busy", int'(bus.BUSY), 1);
    async_reset();
    chk("mid_QR", int'(bus.QR), 0);
    chk("mid_BUSY", int'(bus.BUSY), 0);
    cmd(1, 1, 0, 'h5A5, 0, 0);
    chk("post_rst_load", int'(bus.QR), 'h5A5);

    // Parity
`ifdef REGISTRO_PARIDAD_EN
    exp_par7 = 1;
`else
    exp_par7 = 0;
`endif
    cmd(1, 1, 0, 'h007, 0, 0);
    chk("par_007", int'(bus.PAR), exp_par7);
    cmd(1, 1, 0, 'h003, 0, 0);
    chk("par_003", int'(bus.PAR), 0);

    // Randomized traffic, biased toward count boundaries
    for (int i = 0; i < 1500; i++) begin
      int l;
      case ($urandom_range(0, 3))
        0:       l = 0;
        1:       l = MASK;
        default: l = int'($urandom_range(0, MASK));
      endcase
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        cmd(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)), l,
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/registro_universal.md
# registro_universal

Parametrised successor to the 12-bit enabled register: a WIDTH-bit universal register with parallel load, shift, rotate and up/down count modes. It adds a multi-cycle burst shifter driven by a small FSM, serial I/O for chaining, and status flags. It drops into the same datapath slot as the plain register (L in, QR out, CLK/CLR/EN control) and is driven by the same style of probador/testbench pair.

## Interface
- WIDTH, 12, register width (≥2); CW = $clog2(WIDTH) is a derived localparam.
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous, active-low reset.
- EN  input  1  command strobe; command accepted on a rising edge with EN=1 and BUSY=0.
- MODE  input  3  command: 000 hold, 001 load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110 count up, 111 count down.
- CNT  input  CW  burst length for modes 010–101: performs CNT+1 steps.
- L  input  WIDTH  parallel load data.
- SIN_R  input  1  serial in entering at bit 0 on shift left.
- SIN_L  input  1  serial in entering at bit WIDTH-1 on shift right.
- QR  output  WIDTH  register contents.
- SOUT_L  output  1  QR[WIDTH-1], combinational.
- SOUT_R  output  1  QR[0], combinational.
- BUSY  output  1  burst in progress; commands ignored.
- ZERO  output  1  QR == 0, combinational.
- OVF  output  1  sticky count wrap flag.
- PAR  output  1  parity (see Configuration).

## Operation
- FSM states: IDLE, BURST. A 1-bit registered opcode latch (left/right) plus a rotate/shift bit and a CW-bit remaining-step counter live alongside.
- IDLE, EN=0 or MODE=000: QR holds.
- IDLE, EN=1:
  - 001: QR←L; OVF←0.
  - 110: QR←QR+1 mod 2^WIDTH. If old QR was all-ones, OVF←1.
  - 111: QR←QR−1 mod 2^WIDTH. If old QR was 0, OVF←1.
  - 010–101: first step executes at this edge. If CNT=0 the state stays IDLE. Otherwise go to BURST with remaining=CNT.
- Step definitions:
  - Shift left: {QR[W-2:0],SIN_R}.
  - Shift right: {SIN_L,QR[W-1:1]}.
  - Rotate left: {QR[W-2:0],QR[W-1]}.
  - Rotate right: {QR[0],QR[W-1:1]}.
- BURST: one step per edge using the latched operation. Serial inputs are sampled live at each step edge. remaining decrements each edge; on the edge where remaining=1, perform the last step and return to IDLE.
- EN, MODE, CNT and L are ignored while BUSY=1. There is no command queueing.
- OVF is changed only by count wrap (set), load (clear) or reset (clear). Shift/rotate do not touch it.
- A CNT+1 value above WIDTH is legal. Shifts of ≥WIDTH steps fully flush QR with serial data; rotates wrap modulo WIDTH.

## Timing
- Reset (CLR=0, asynchronous, immediate):
  - QR=0, BUSY=0, OVF=0, FSM=IDLE, remaining=0.
  - Hence ZERO=1, SOUT_L=0, SOUT_R=0, PAR=0.
- Reset mid-burst aborts the burst. Operation resumes on the first rising edge after CLR deasserts.
- Single-cycle ops have latency 1: QR is valid after the accepting edge.
- Burst of CNT+1 steps:
  - Occupies edges t0..t0+CNT; BUSY=1 from after t0 until after t0+CNT.
  - The next command can be accepted at edge t0+CNT+1.
- Flags (ZERO, SOUT_x, PAR) are combinational from QR and therefore valid in the same cycle as QR.

## Configuration
- REGISTRO_PARIDAD_EN defined: PAR = ^QR (even-parity indicator, combinational).
- REGISTRO_PARIDAD_EN undefined: PAR is tied to 0 and no XOR tree is synthesised.
- The port list is identical in both builds.

## Test plan
All scenarios use WIDTH=12.
- Reset and load: CLR=0 with QR arbitrary → QR=0x000, ZERO=1, BUSY=0. Then CLR=1, EN=1, MODE=001, L=0xA5C → QR=0xA5C after 1 edge.
- Burst shift: QR=0x001, MODE=010, CNT=3, SIN_R=1 → BUSY high for 3 cycles; QR sequence 0x003, 0x007, 0x00F, 0x01F. A command issued during BUSY is ignored.
- Rotate wrap: QR=0x801, MODE=101, CNT=0 → QR=0xC00, BUSY stays 0. Then MODE=100, CNT=11 → QR returns to 0xC00 after 12 steps.
- Count wrap: QR=0xFFF, MODE=110 → QR=0x000, OVF=1, ZERO=1. MODE=111 → QR=0xFFF, OVF stays 1. MODE=001 → OVF=0.
- Reset mid-burst: start MODE=011, CNT=7, then assert CLR after 2 steps → QR=0, BUSY=0 immediately. After release, a MODE=001 command is accepted on the next edge.
- Parity: with REGISTRO_PARIDAD_EN, load 0x007 → PAR=1, load 0x003 → PAR=0. Without the macro, PAR=0 for both.
